// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide controller owning the HI/LO registers
//
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     synchronous, active-high reset
//   start     request strobe, qualified by mdu_op
//   mdu_op    0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   src_a     rs operand
//   src_b     rt operand
//   busy      multi-cycle operation in progress
//   stall_req busy, or a multi-cycle request arriving this cycle
//   hi, lo    architectural HI/LO registers

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        long_op;
    logic        accept;
    logic        finish;
    logic        mt_write;

    assign long_op   = (mdu_op != 3'd0) && (mdu_op <= 3'd4);
    assign busy      = (state == RUN);
    assign stall_req = busy || (start && long_op);

    // Next-state / sequencing
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        finish     = 1'b0;
        mt_write   = 1'b0;
        case (state)
            IDLE: begin
                if (start && long_op) begin
                    accept     = 1'b1;
                    state_next = RUN;
                    count_next = (mdu_op <= 3'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                end else if (start && (mdu_op == 3'd5 || mdu_op == 3'd6)) begin
                    mt_write = 1'b1;
                end
            end
            RUN: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arithmetic on the latched operands; only the write is sequenced
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_s_b, div_u_b;
    logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;

    always_comb begin
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        abs_a   = a_q[31] ? -a_q : a_q;
        abs_b   = b_q[31] ? -b_q : b_q;
        // Zero divisor never writes; substitute 1 so the divider never sees /0
        div_s_b = (b_q == 32'd0) ? 32'd1 : abs_b;
        div_u_b = (b_q == 32'd0) ? 32'd1 : b_q;
        // Magnitude divide, then fix signs; 0x80000000 / -1 falls out as 0x80000000
        uq_s    = abs_a / div_s_b;
        ur_s    = abs_a % div_s_b;
        q_s     = (a_q[31] ^ b_q[31]) ? -uq_s : uq_s;
        r_s     = a_q[31] ? -ur_s : ur_s;
        q_u     = a_q / div_u_b;
        r_u     = a_q % div_u_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                op_q <= mdu_op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
            if (mt_write) begin
                if (mdu_op == 3'd5) hi <= src_a;
                else                lo <= src_a;
            end
            if (finish) begin
                case (op_q)
                    3'd1: {hi, lo} <= prod_s;
                    3'd2: {hi, lo} <= prod_u;
                    3'd3: if (b_q != 32'd0) begin
                        lo <= q_s;
                        hi <= r_s;
                    end
                    3'd4: if (b_q != 32'd0) begin
                        lo <= q_u;
                        hi <= r_u;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl

module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a, src_b;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        mdu_op = 3'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
    endtask

    // Reference model: results from plain 64-bit arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd2: {m_hi, m_lo} = 64'(a) * 64'(b);
            3'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue a multi-cycle op; with inject set, throw MTHI then DIVU at it while busy
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int n;
        int lat;
        logic [31:0] old_hi, old_lo;
        lat    = (op <= 3'd2) ? MC : DC;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1; mdu_op = op; src_a = a; src_b = b;
        #1;
        chk({tag, " stall_on_req"}, 32'(stall_req), 32'd1);
        step();
        idle_inputs();
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            chk({tag, " stall_eq_busy"}, 32'(stall_req), 32'd1);
            chk({tag, " hi_hold"}, hi, old_hi);
            chk({tag, " lo_hold"}, lo, old_lo);
            n++;
            if (inject && n == 1) begin
                start = 1'b1; mdu_op = 3'd5; src_a = 32'hAA; src_b = 32'd0;
            end else if (inject && n == 2) begin
                start = 1'b1; mdu_op = 3'd4; src_a = 32'd100; src_b = 32'd7;
            end else begin
                idle_inputs();
            end
            step();
        end
        idle_inputs();
        model(op, a, b);
        chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; mdu_op = op; src_a = a; src_b = 32'hDEAD;
        #1;
        chk({tag, " stall"}, 32'(stall_req), 32'd0);
        step();
        idle_inputs();
        model(op, a, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);

        run_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_neg hi_const", hi, 32'hFFFFFFFF);
        chk("mult_neg lo_const", lo, 32'hFFFFFFFA);

        run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_max hi_const", hi, 32'hFFFFFFFE);
        chk("multu_max lo_const", lo, 32'h00000001);

        run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_neg lo_const", lo, 32'hFFFFFFFD);
        chk("div_neg hi_const", hi, 32'hFFFFFFFF);

        run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_7_2 lo_const", lo, 32'd3);
        chk("divu_7_2 hi_const", hi, 32'd1);

        run_mt("mthi", 3'd5, 32'h11);
        run_mt("mtlo", 3'd6, 32'h22);
        run_op("div_zero", 3'd3, 32'd1234, 32'd0, 1'b0);
        chk("div_zero hi_const", hi, 32'h11);
        chk("div_zero lo_const", lo, 32'h22);

        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf lo_const", lo, 32'h80000000);
        chk("div_ovf hi_const", hi, 32'd0);

        run_op("mult_ignore", 3'd1, 32'd6, 32'd7, 1'b1);
        chk("mult_ignore lo_const", lo, 32'd42);
        chk("mult_ignore hi_not_aa", 32'(hi == 32'hAA), 32'd0);

        // Ops 0 and 7 do nothing
        start = 1'b1; mdu_op = 3'd0; src_a = 32'h5555; src_b = 32'd3;
        #1;
        chk("nop0 stall", 32'(stall_req), 32'd0);
        step();
        mdu_op = 3'd7;
        #1;
        chk("nop7 stall", 32'(stall_req), 32'd0);
        step();
        idle_inputs();
        chk("nop busy", 32'(busy), 32'd0);
        chk("nop hi", hi, m_hi);
        chk("nop lo", lo, m_lo);

        // Reset during the 4th busy cycle of a DIV
        start = 1'b1; mdu_op = 3'd3; src_a = 32'd100; src_b = 32'd3;
        step();
        idle_inputs();
        for (int i = 1; i < 4; i++) step();
        chk("rstmid busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid hi", hi, 32'd0);
        chk("rstmid lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) step();
        chk("rstmid late_busy", 32'(busy), 32'd0);
        chk("rstmid late_hi", hi, 32'd0);
        chk("rstmid late_lo", lo, 32'd0);
        run_mt("mtlo_1234", 3'd6, 32'h1234);
        chk("mtlo_1234 lo_const", lo, 32'h1234);

        // Randomized back-to-back operations against the model
        for (int k = 0; k < 16; k++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (rop <= 3'd4) run_op("rand_op", rop, ra, rb, 1'b0);
            else             run_mt("rand_mt", rop, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit controller for the MIPS pipeline. It sits beside the ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, sequences each multi-cycle operation with a latency counter, and owns the architectural HI/LO registers. It reports busy status so hazard logic can stall MFHI/MFLO and further MDU instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, qualified by mdu_op, sampled each cycle
mdu_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
src_a  input  32  rs operand
src_b  input  32  rt operand
busy  output  1  operation in progress
stall_req  output  1  combinational: busy OR (start AND mdu_op in 1..4)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- One clock domain, clk. reset is synchronous and active-high: on a reset edge, state=IDLE, count=0, busy=0, hi=0, lo=0, and latched operands=0.
- States: IDLE and RUN. A 4-bit down-counter `count` and a 3-bit latched op `op_q`.
- In IDLE, if start=1 and mdu_op is 1..4 in cycle T:
  - At the T edge, latch src_a, src_b and op into internal registers.
  - Load count with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4), and go to RUN.
  - busy=1 during cycles T+1 .. T+N, where N is the loaded latency.
- In RUN, count decrements each cycle. On the edge where count==1:
  - Write hi/lo from the latched operands.
  - Go to IDLE; busy=0 from cycle T+N+1.
  - hi/lo keep their old values for the whole of the busy window.
- Results:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divisor 0: hi and lo are left unchanged, but the full DIV_CYCLES busy period still elapses.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: when start=1 and busy=0, write src_a into hi or lo at that edge. busy stays 0 (single-cycle).
- Any start while busy=1 is ignored, whatever the op. This means no queueing and the latched operands are not overwritten; the upstream pipeline guarantees a stall via stall_req. The bench checks that ignoring occurs.
- start with op 0 or 7: no effect.
- Back-to-back: start may be accepted in the same cycle busy first reads 0 (cycle T+N+1). The new operation uses src_a/src_b as sampled in that cycle.
- Reset asserted mid-RUN: the operation is aborted, state returns to IDLE, and hi/lo are cleared to 0. No result write occurs.
- The arithmetic may be computed combinationally from the latched operands; only the write timing is sequenced.

Test Plan:
- Reset, then start MULT with src_a=0xFFFFFFFE (-2), src_b=3 -> busy high for exactly 5 cycles. Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA, with hi/lo unchanged during busy.
- MULTU with src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV with src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Follow with DIVU 7/2 -> lo=3, hi=1.
- DIV with src_b=0 while hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, then during busy assert start with MTHI src_a=0xAA and with DIVU -> both ignored; the product lands after 5 cycles and hi is not 0xAA. stall_req=1 whenever busy=1.
- Start DIV, assert reset at busy cycle 4 -> busy=0, hi=lo=0 on the next cycle, and no later write. Then MTLO src_a=0x1234 -> lo=0x1234 one edge later, with busy never asserted.
